// File: rtl/jump_redirect_ctrl.sv
// Jump redirect controller: holds fetch/decode on jr/jalr conflicts, then redirects PC after the delay slot.
// Latency: redirect fires in the first ARMED cycle with ds_validF & fetch_ready; outputs combinational from registered state.
// Backpressure: fetch_ready=0 while the delay slot is in keeps stallF high and the target armed until IF accepts.
module jump_redirect_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        validD,
  input  logic        jumpD,
  input  logic        jump_conflictD,
  input  logic [31:0] pc_jumpD,
  input  logic        stall_extD,
  input  logic        flush_exc,
  input  logic        ds_validF,
  input  logic        fetch_ready,
  output logic        stallF,
  output logic        stallD,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [31:0] jump_cnt,
  output logic [15:0] conflict_cycles,
  output logic        err_nested
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOLD  = 2'b01,
    ARMED = 2'b10
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] tgt_q;
  logic        accept;
  logic        latch;
  logic        fire;

  assign accept = validD & jumpD & ~stall_extD & ~flush_exc;

  // Next-state and stall/redirect decode; an exception flush overrides everything.
  always_comb begin
    state_d        = state_q;
    stallF         = 1'b0;
    stallD         = 1'b0;
    redirect_valid = 1'b0;
    latch          = 1'b0;
    fire           = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (jump_conflictD) begin
            state_d = HOLD;
          end else begin
            latch   = 1'b1;
            state_d = ARMED;
          end
        end
      end
      HOLD: begin
        stallF = 1'b1;
        if (!jump_conflictD && !stall_extD) begin
          // Source register is now readable: capture target and let decode advance.
          latch   = 1'b1;
          state_d = ARMED;
        end else begin
          stallD = 1'b1;
        end
      end
      ARMED: begin
        if (ds_validF) begin
          if (fetch_ready) begin
            redirect_valid = 1'b1;
            fire           = 1'b1;
            state_d        = IDLE;
          end else begin
            stallF = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_exc) begin
      stallF         = 1'b0;
      stallD         = 1'b0;
      redirect_valid = 1'b0;
      latch          = 1'b0;
      fire           = 1'b0;
      state_d        = IDLE;
    end
  end

  // State register and captured jump target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (latch) tgt_q <= pc_jumpD;
    end
  end

  // Statistics: fired redirects (wrapping), HOLD cycles (saturating), sticky nested-jump flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jump_cnt        <= 32'd0;
      conflict_cycles <= 16'd0;
      err_nested      <= 1'b0;
    end else begin
      if (fire) jump_cnt <= jump_cnt + 32'd1;
      if (state_q == HOLD && conflict_cycles != 16'hFFFF)
        conflict_cycles <= conflict_cycles + 16'd1;
      if (state_q == ARMED && validD && jumpD) err_nested <= 1'b1;
    end
  end

  assign redirect_pc = tgt_q;
  assign busy        = (state_q != IDLE);

endmodule
